// File: rtl/alu_vector_gen.sv
// Stimulus generator for the ALU: streams {srcA, srcB, ALUOPCtrl} vectors over valid/ready,
// first an optional 16-vector corner sweep, then num_vec vectors from two 32-bit LFSRs.
module alu_vector_gen #(
  parameter logic [31:0] SEED_A   = 32'h1234_5678,
  parameter logic [31:0] SEED_B   = 32'h8765_4321,
  parameter logic [4:0]  OP_FIRST = 5'd0,
  parameter logic [4:0]  OP_LAST  = 5'd31,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en_corner,
  input  logic [CNT_W-1:0] num_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      srcA,
  output logic [31:0]      srcB,
  output logic [4:0]       ALUOPCtrl,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CORNER = 2'd1;
  localparam logic [1:0] S_RANDOM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  logic [1:0]       state;
  logic [31:0]      lfsr_a;
  logic [31:0]      lfsr_b;
  logic [4:0]       op;
  logic [3:0]       corner_k;
  logic [CNT_W-1:0] rand_left;
  logic             xfer;
  logic [4:0]       next_op;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [31:0] corner_val(input logic [1:0] sel);
    logic [31:0] v;
    case (sel)
      2'd0:    v = 32'h0000_0000;
      2'd1:    v = 32'h0000_0001;
      2'd2:    v = 32'h7FFF_FFFF;
      default: v = 32'h8000_0000;
    endcase
    return v;
  endfunction

  // Handshake: a vector moves on every posedge where out_valid and out_ready are both high;
  // while out_valid is high and out_ready low, every output stays unchanged.
  assign busy      = (state == S_CORNER) || (state == S_RANDOM);
  assign done      = (state == S_DONE);
  assign out_valid = busy;
  assign xfer      = out_valid && out_ready;
  assign next_op   = (op == OP_LAST) ? OP_FIRST : op + 5'd1;
  assign ALUOPCtrl = busy ? op : 5'd0;

  always_comb begin
    srcA = 32'h0;
    srcB = 32'h0;
    case (state)
      S_CORNER: begin
        srcA = corner_val(corner_k[3:2]);
        srcB = corner_val(corner_k[1:0]);
      end
      S_RANDOM: begin
        srcA = lfsr_a;
        srcB = lfsr_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr_a    <= SEED_A_EFF;
      lfsr_b    <= SEED_B_EFF;
      op        <= OP_FIRST;
      corner_k  <= 4'd0;
      rand_left <= '0;
      vec_idx   <= '0;
    end else begin
      if (xfer) begin
        vec_idx <= vec_idx + CNT_W'(1);
        op      <= next_op;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr_a    <= SEED_A_EFF;
            lfsr_b    <= SEED_B_EFF;
            op        <= OP_FIRST;
            corner_k  <= 4'd0;
            rand_left <= num_vec;
            vec_idx   <= '0;
            if (en_corner)             state <= S_CORNER;
            else if (num_vec != '0)    state <= S_RANDOM;
            else                       state <= S_DONE;
          end
        end
        S_CORNER: begin
          if (xfer) begin
            corner_k <= corner_k + 4'd1;
            if (corner_k == 4'd15) state <= (rand_left != '0) ? S_RANDOM : S_DONE;
          end
        end
        S_RANDOM: begin
          if (xfer) begin
            lfsr_a    <= lfsr_step(lfsr_a);
            lfsr_b    <= lfsr_step(lfsr_b);
            rand_left <= rand_left - CNT_W'(1);
            if (rand_left == CNT_W'(1)) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_gen.sv
// Bench for alu_vector_gen: a vector-list model checked every cycle against two instances
// (full opcode range and a narrow 3..5 range), plus literal expectations per scenario.
module tb_alu_vector_gen;
  localparam int CNT_W = 16;
  localparam logic [31:0] TB_SEED_B = 32'h8765_4321;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             en_corner;
  logic [CNT_W-1:0] num_vec;
  logic             out_ready;

  logic             v0, bz0, d0, v1, bz1, d1;
  logic [31:0]      a0, b0, a1, b1;
  logic [4:0]       o0, o1;
  logic [CNT_W-1:0] i0, i1;

  alu_vector_gen #(.SEED_A(32'h1), .SEED_B(TB_SEED_B), .OP_FIRST(5'd0), .OP_LAST(5'd31),
                   .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .en_corner(en_corner), .num_vec(num_vec),
    .out_valid(v0), .out_ready(out_ready), .srcA(a0), .srcB(b0), .ALUOPCtrl(o0),
    .vec_idx(i0), .busy(bz0), .done(d0));

  alu_vector_gen #(.SEED_A(32'h1), .SEED_B(TB_SEED_B), .OP_FIRST(5'd3), .OP_LAST(5'd5),
                   .CNT_W(CNT_W)) dut_op (
    .clk(clk), .rst(rst), .start(start), .en_corner(en_corner), .num_vec(num_vec),
    .out_valid(v1), .out_ready(out_ready), .srcA(a1), .srcB(b1), .ALUOPCtrl(o1),
    .vec_idx(i1), .busy(bz1), .done(d1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model: the whole run's expected {srcA, srcB} list, built when a start is accepted.
  logic [63:0]      exp_q[$];
  logic             m_active = 1'b0;
  logic             m_done = 1'b0;
  logic [CNT_W-1:0] m_idx = '0;
  int               run_i = 0;

  // Accepted transfers as seen on the outputs, for literal checks.
  logic [31:0]      got_a[$];
  logic [31:0]      got_b[$];
  logic [4:0]       got_o0[$];
  logic [4:0]       got_o1[$];
  logic [CNT_W-1:0] got_idx[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [31:0] corner_c(input int s);
    case (s)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic build_run(input logic ec, input logic [CNT_W-1:0] n);
    logic [31:0] la;
    logic [31:0] lb;
    la = 32'h1;
    lb = TB_SEED_B;
    exp_q.delete();
    if (ec) for (int k = 0; k < 16; k++) exp_q.push_back({corner_c(k / 4), corner_c(k % 4)});
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({la, lb});
      la = lfsr_next(la);
      lb = lfsr_next(lb);
    end
  endtask

  // Compare on the falling edge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    logic [31:0] ea, eb;
    logic [4:0]  eo0, eo1;
    ea = 32'h0; eb = 32'h0; eo0 = 5'd0; eo1 = 5'd0;
    if (m_active) begin
      ea  = exp_q[0][63:32];
      eb  = exp_q[0][31:0];
      eo0 = 5'(run_i % 32);
      eo1 = 5'(3 + run_i % 3);
    end
    if (chk_en) begin
      check("valid0", 64'(v0), 64'(m_active));
      check("srcA0", 64'(a0), 64'(ea));
      check("srcB0", 64'(b0), 64'(eb));
      check("op0", 64'(o0), 64'(eo0));
      check("idx0", 64'(i0), 64'(m_idx));
      check("busy0", 64'(bz0), 64'(m_active));
      check("done0", 64'(d0), 64'(m_done));
      check("valid1", 64'(v1), 64'(m_active));
      check("srcA1", 64'(a1), 64'(ea));
      check("srcB1", 64'(b1), 64'(eb));
      check("op1", 64'(o1), 64'(eo1));
      check("idx1", 64'(i1), 64'(m_idx));
      check("busy1", 64'(bz1), 64'(m_active));
      check("done1", 64'(d1), 64'(m_done));
      if (v0 && out_ready && !rst) begin
        got_a.push_back(a0); got_b.push_back(b0);
        got_o0.push_back(o0); got_o1.push_back(o1); got_idx.push_back(i0);
      end
    end
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_idx = '0; run_i = 0;
      exp_q.delete();
    end else if (m_active) begin
      if (out_ready) begin
        void'(exp_q.pop_front());
        m_idx++;
        run_i++;
        if (exp_q.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start) begin
      build_run(en_corner, num_vec);
      m_idx = '0;
      run_i = 0;
      m_done   = (exp_q.size() == 0);
      m_active = (exp_q.size() != 0);
    end
  end

  task automatic clear_log();
    got_a.delete(); got_b.delete(); got_o0.delete(); got_o1.delete(); got_idx.delete();
  endtask

  task automatic drive_start(input logic ec, input logic [CNT_W-1:0] n);
    start = 1'b1; en_corner = ec; num_vec = n; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // stall=1 applies the out_ready pattern 1,0,0,1 repeatedly.
  task automatic wait_done(input bit stall, input int budget);
    int c;
    logic [3:0] pat;
    c = 0;
    pat = 4'b1001;
    while (!d0 && c < budget) begin
      out_ready = stall ? pat[3 - (c % 4)] : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    if (c >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en_corner = 1'b0; num_vec = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_valid", 64'(v0), 64'(0));
    check("reset_idx", 64'(i0), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: three random vectors, LFSR A seeded with 1
    clear_log();
    drive_start(1'b0, 16'd3);
    wait_done(1'b0, 50);
    check("t1_count", 64'(got_a.size()), 64'(3));
    if (got_a.size() == 3) begin
      check("t1_a0", 64'(got_a[0]), 64'(32'h1));
      check("t1_a1", 64'(got_a[1]), 64'(32'h3));
      check("t1_a2", 64'(got_a[2]), 64'(32'h6));
      check("t1_b0", 64'(got_b[0]), 64'(32'h8765_4321));
      check("t1_op2", 64'(got_o0[2]), 64'(2));
      check("t1_idx2", 64'(got_idx[2]), 64'(2));
    end
    check("t1_done", 64'(d0), 64'(1));

    // 2: corner sweep only
    clear_log();
    drive_start(1'b1, 16'd0);
    wait_done(1'b0, 60);
    check("t2_count", 64'(got_a.size()), 64'(16));
    if (got_a.size() == 16) begin
      check("t2_k6", {got_a[6], got_b[6]}, {32'h1, 32'h7FFF_FFFF});
      check("t2_k15", {got_a[15], got_b[15]}, {32'h8000_0000, 32'h8000_0000});
      check("t2_k9", {got_a[9], got_b[9]}, {32'h7FFF_FFFF, 32'h1});
    end

    // 3: corner + random under a stalling consumer
    clear_log();
    drive_start(1'b1, 16'd2);
    wait_done(1'b1, 200);
    check("t3_count", 64'(got_a.size()), 64'(18));
    if (got_a.size() == 18) begin
      int seq_bad;
      seq_bad = 0;
      for (int i = 0; i < 18; i++) if (got_idx[i] != CNT_W'(i)) seq_bad++;
      check("t3_idx_seq", 64'(seq_bad), 64'(0));
      check("t3_first_rand", 64'(got_a[16]), 64'(32'h1));
      check("t3_op17", 64'(got_o0[17]), 64'(17));
    end

    // 4: narrow opcode range wraps 3,4,5,3,4
    clear_log();
    drive_start(1'b0, 16'd5);
    wait_done(1'b0, 50);
    check("t4_ops", {24'h0, got_o1.size() == 5 ? {got_o1[0], got_o1[1], got_o1[2], got_o1[3], got_o1[4]} : 25'h1FFFFFF, 15'h0},
          {24'h0, 5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 15'h0});

    // 5: reset at the second transfer, then restart
    clear_log();
    drive_start(1'b0, 16'd6);
    begin
      int c;
      c = 0;
      while (got_a.size() < 1 && c < 50) begin @(posedge clk); #1; c++; end
      check("t5_first_xfer", 64'(got_a.size()), 64'(1));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_valid", 64'(v0), 64'(0));
    check("t5_rst_srcA", 64'(a0), 64'(0));
    clear_log();
    drive_start(1'b0, 16'd6);
    wait_done(1'b0, 50);
    check("t5_count", 64'(got_a.size()), 64'(6));
    if (got_a.size() == 6) check("t5_a01", {got_a[0], got_a[1]}, {32'h1, 32'h3});

    // 6: start while busy is ignored; empty run; start held in DONE
    clear_log();
    drive_start(1'b0, 16'd4);
    start = 1'b1; en_corner = 1'b1; num_vec = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 50);
    check("t6_ignored", 64'(got_a.size()), 64'(4));
    clear_log();
    drive_start(1'b0, 16'd0);
    check("t6_empty_done", 64'(d0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("t6_empty_count", 64'(got_a.size()), 64'(0));
    clear_log();
    start = 1'b1; en_corner = 1'b0; num_vec = 16'd1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, 20);
    check("t6_held_count", 64'(got_a.size()), 64'(2));

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
